// File: rtl/multdiv_unit_if.sv
// Request/result bundle between the pipeline and the multi-cycle multiply/divide unit.
// The master side issues operands and start strobes; the slave side returns the registered result.
interface multdiv_unit_if;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// Signed 32-bit Booth multiply / restoring divide; result and one-cycle RDY 33 edges after the start edge.
// No backpressure: start requests are ignored whenever the unit is not IDLE.
module multdiv_unit (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] acc_q, acc_d;
  logic [31:0] m_q, m_d;
  logic        neg_q, neg_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;

  logic [31:0] a_mag, b_mag, quo_signed;
  logic [32:0] booth_sum;
  logic [32:0] rem_sh;
  logic [33:0] rem_diff;

  // Multiply: acc = {A[31:0], Q[31:0], q-1}. The add runs 33 bits wide so that
  // subtracting the most negative multiplicand cannot wrap before the shift.
  always_comb begin
    booth_sum = {acc_q[64], acc_q[64:33]};
    case (acc_q[1:0])
      2'b01:   booth_sum = {acc_q[64], acc_q[64:33]} + {m_q[31], m_q};
      2'b10:   booth_sum = {acc_q[64], acc_q[64:33]} - {m_q[31], m_q};
      default: booth_sum = {acc_q[64], acc_q[64:33]};
    endcase
  end

  // Divide: acc = {remainder[32:0], quotient/dividend[31:0]} on magnitudes.
  assign rem_sh     = {acc_q[63:32], acc_q[31]};
  assign rem_diff   = {1'b0, rem_sh} - {2'b00, m_q};
  assign quo_signed = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

  assign a_mag = bus.data_operandA[31] ? (32'd0 - bus.data_operandA) : bus.data_operandA;
  assign b_mag = bus.data_operandB[31] ? (32'd0 - bus.data_operandB) : bus.data_operandB;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    m_d      = m_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ctrl_MULT) begin
          state_d = MULT;
          cnt_d   = 6'd0;
          acc_d   = {32'd0, bus.data_operandA, 1'b0};
          m_d     = bus.data_operandB;
        end else if (bus.ctrl_DIV) begin
          state_d = DIV;
          cnt_d   = 6'd0;
          acc_d   = {33'd0, a_mag};
          m_d     = b_mag;
          neg_d   = bus.data_operandA[31] ^ bus.data_operandB[31];
          dz_d    = (bus.data_operandB == 32'd0);
          ovf_d   = (bus.data_operandA == 32'h8000_0000) && (bus.data_operandB == 32'hFFFF_FFFF);
        end
      end
      MULT: begin
        if (cnt_q == 6'd32) begin
          state_d  = DONE;
          rdy_d    = 1'b1;
          result_d = acc_q[32:1];
          exc_d    = (acc_q[64:33] != {32{acc_q[32]}});
        end else begin
          cnt_d = cnt_q + 6'd1;
          acc_d = {booth_sum, acc_q[32:1]};
        end
      end
      DIV: begin
        if (cnt_q == 6'd32) begin
          state_d = DONE;
          rdy_d   = 1'b1;
          if (dz_q) begin
            result_d = 32'd0;
            exc_d    = 1'b1;
          end else begin
            result_d = quo_signed;
            exc_d    = ovf_q;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!rem_diff[33]) acc_d = {rem_diff[32:0], acc_q[30:0], 1'b1};
          else               acc_d = {rem_sh, acc_q[30:0], 1'b0};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      acc_q    <= 65'd0;
      m_q      <= 32'd0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed cases, control-ignore, reset abort and
// randomized operations scored against a plain-arithmetic reference model.
module tb_multdiv_unit;

  logic clock;
  logic reset;
  multdiv_unit_if bus ();

  multdiv_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] prev_res;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference: full-precision signed arithmetic, divide truncating toward zero.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit is_mult,
                       output logic [31:0] r, output logic e);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_mult) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = sa / sb;
      r = q[31:0];
      e = (q > 64'sd2147483647);
    end
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 40)) - 32'd20;
      2:       v = 32'd0;
      3:       v = 32'h8000_0000;
      4:       v = 32'hFFFF_FFFF;
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  // Issues one request at the current negedge, then follows it edge by edge.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic d, input logic [31:0] er,
                        input logic ee, input bit inject);
    int          lat, rdy_cnt;
    logic [31:0] got_res;
    logic        got_exc;
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    @(posedge clock);
    @(negedge clock);
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", nm, bus.busy); else pass_cnt++;
    lat = 0; rdy_cnt = 0; got_res = 'x; got_exc = 'x;
    for (int k = 1; k <= 34; k++) begin
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      bus.ctrl_MULT     = inject && (k == 20);
      bus.ctrl_DIV      = inject && (k == 10);
      @(posedge clock);
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (lat == 0) begin
          lat     = k;
          got_res = bus.data_result;
          got_exc = bus.data_exception;
        end
      end
      if (k == 32) begin
        total_cnt++; if (bus.data_result !== prev_res) $display("FAIL %s result_before_done: got %h want %h", nm, bus.data_result, prev_res); else pass_cnt++;
      end
      if (k == 34) begin
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL %s busy_after_done: got %b want 0", nm, bus.busy); else pass_cnt++;
        total_cnt++; if (bus.data_result !== er) $display("FAIL %s result_held: got %h want %h", nm, bus.data_result, er); else pass_cnt++;
        total_cnt++; if (bus.data_exception !== ee) $display("FAIL %s exception_held: got %b want %b", nm, bus.data_exception, ee); else pass_cnt++;
      end
    end
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    total_cnt++; if (lat !== 33) $display("FAIL %s rdy_latency: got %0d want 33", nm, lat); else pass_cnt++;
    total_cnt++; if (rdy_cnt !== 1) $display("FAIL %s rdy_width: got %0d want 1", nm, rdy_cnt); else pass_cnt++;
    total_cnt++; if (got_res !== er) $display("FAIL %s result: got %h want %h", nm, got_res, er); else pass_cnt++;
    total_cnt++; if (got_exc !== ee) $display("FAIL %s exception: got %b want %b", nm, got_exc, ee); else pass_cnt++;
    prev_res = er;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_operandA = 32'd0;
    bus.data_operandB = 32'd0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++; if (bus.data_result !== 32'd0) $display("FAIL reset_result: got %h want 0", bus.data_result); else pass_cnt++;
    total_cnt++; if (bus.data_exception !== 1'b0) $display("FAIL reset_exception: got %b want 0", bus.data_exception); else pass_cnt++;
    total_cnt++; if (bus.data_resultRDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", bus.data_resultRDY); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else pass_cnt++;
    reset = 1'b0;
    prev_res = 32'd0;
    @(negedge clock);
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_mult();
    run_op("mul_7_x_m6",    32'h0000_0007, 32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0, 1'b0);
    run_op("mul_ovf",       32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("mul_minint_x1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_m7_2",      32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    // 100 / -7 truncates to -14
    run_op("div_100_m7",    32'd100,       32'hFFFF_FFF9, 1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0, 1'b0);
    run_op("div_by_zero",   32'd5,         32'd0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("div_minint_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_ctrl();
    run_op("mul_ignore_ctrl", 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0, 1'b1);
    run_op("mul_div_both",    32'd9, 32'd3, 1'b1, 1'b1, 32'd27, 1'b0, 1'b0);
  endtask

  task automatic test_reset_abort();
    bus.data_operandA = 32'd3;
    bus.data_operandB = 32'd4;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (9) begin
      bus.data_operandA = $urandom;
      bus.data_operandB = $urandom;
      @(posedge clock);
      @(negedge clock);
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    total_cnt++; if (bus.data_result !== 32'd0) $display("FAIL abort_result: got %h want 0", bus.data_result); else pass_cnt++;
    total_cnt++; if (bus.data_exception !== 1'b0) $display("FAIL abort_exception: got %b want 0", bus.data_exception); else pass_cnt++;
    total_cnt++; if (bus.data_resultRDY !== 1'b0) $display("FAIL abort_rdy: got %b want 0", bus.data_resultRDY); else pass_cnt++;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.busy); else pass_cnt++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    prev_res = 32'd0;
    run_op("div_after_reset", 32'd12, 32'd4, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] a, b, er;
    logic        ee, is_mult;
    for (int i = 0; i < 16; i++) begin
      a       = pick_operand();
      b       = pick_operand();
      is_mult = $urandom_range(0, 1);
      model(a, b, is_mult, er, ee);
      run_op(is_mult ? "rand_mul" : "rand_div", a, b, is_mult, !is_mult, er, ee, (i % 4) == 3);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_ignore_ctrl();
    test_reset_abort();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
